mem_accumulator: RTL and testbench

MEM_ACCUMULATOR -- requirements
Module: mem_accumulator

---
 rtl/mem_acc_pkg.sv | 19 +
 rtl/mem_acc_datapath.sv | 61 ++++++
 rtl/mem_accumulator.sv | 111 +++++++++++
 tb/tb_mem_accumulator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_acc_pkg.sv
// Shared types for the memory accumulator: controller state encoding and operation modes.
package mem_acc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_ACC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'd0,
    MODE_SAT  = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_MIN  = 2'd3
  } mode_e;

endpackage

// File: rtl/mem_acc_datapath.sv
// Accumulator register, mode ALU (wrap/saturating sum, unsigned max/min) and the sticky overflow flag.
module mem_acc_datapath
  import mem_acc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  mode_e             load_mode_i,
  input  logic              acc_en_i,
  input  mode_e             mode_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, data_i};
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (load_i) begin
      // min starts from the top of the range so the first word always wins
      acc_d = (load_mode_i == MODE_MIN) ? '1 : '0;
      ovf_d = 1'b0;
    end else if (acc_en_i) begin
      case (mode_i)
        MODE_WRAP: acc_d = sum[DATA_W-1:0];
        MODE_SAT: begin
          if (sum[DATA_W]) begin
            acc_d = '1;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum[DATA_W-1:0];
          end
        end
        MODE_MAX: acc_d = (data_i > acc_q) ? data_i : acc_q;
        MODE_MIN: acc_d = (data_i < acc_q) ? data_i : acc_q;
        default:  acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/mem_accumulator.sv
// Reads Count words from BaseAddr (wrapping), folds them per Mode and writes the result to DestAddr.
// state | meaning: IDLE wait Start | READ issue read | ACC fold word | WRITE store result | DONE pulse
module mem_accumulator
  import mem_acc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [ADDR_W:0]   Count,
  input  logic [ADDR_W-1:0] DestAddr,
  input  logic [1:0]        Mode,
  input  logic [DATA_W-1:0] DataOut,
  output logic [ADDR_W-1:0] Address,
  output logic              ReadEnable,
  output logic              WriteEnable,
  output logic [DATA_W-1:0] DataIN,
  output logic              Ready,
  output logic              Done,
  output logic              Overflow
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  mode_e             mode_q, mode_d;
  logic              accept;
  logic              acc_en;

  assign accept = (state_q == S_IDLE) && Start;
  assign acc_en = (state_q == S_ACC);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    dest_d      = dest_q;
    mode_d      = mode_q;
    Address     = '0;
    ReadEnable  = 1'b0;
    WriteEnable = 1'b0;
    Ready       = 1'b0;
    Done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        Ready = 1'b1;
        if (Start) begin
          ptr_d   = BaseAddr;
          rem_d   = Count;
          dest_d  = DestAddr;
          mode_d  = mode_e'(Mode);
          state_d = (Count != '0) ? S_READ : S_WRITE;
        end
      end
      S_READ: begin
        ReadEnable = 1'b1;
        Address    = ptr_q;
        state_d    = S_ACC;
      end
      S_ACC: begin
        Address = ptr_q;
        ptr_d   = ptr_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == (ADDR_W+1)'(1)) ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        WriteEnable = 1'b1;
        Address     = dest_q;
        state_d     = S_DONE;
      end
      S_DONE: begin
        Done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      dest_q  <= '0;
      mode_q  <= MODE_WRAP;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      dest_q  <= dest_d;
      mode_q  <= mode_d;
    end
  end

  mem_acc_datapath #(.DATA_W(DATA_W)) u_datapath (
    .clk_i       (Clock),
    .rst_i       (Reset),
    .load_i      (accept),
    .load_mode_i (mode_e'(Mode)),
    .acc_en_i    (acc_en),
    .mode_i      (mode_q),
    .data_i      (DataOut),
    .acc_o       (DataIN),
    .ovf_o       (Overflow)
  );

endmodule

// File: tb/tb_mem_accumulator.sv
// Bench for mem_accumulator: directed vector table, corner sequences and randomized jobs vs a reference model.
module tb_mem_accumulator;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [4:0]  BaseAddr = '0;
  logic [5:0]  Count = '0;
  logic [4:0]  DestAddr = '0;
  logic [1:0]  Mode = '0;
  logic [15:0] DataOut = '0;
  logic [4:0]  Address;
  logic        ReadEnable;
  logic        WriteEnable;
  logic [15:0] DataIN;
  logic        Ready;
  logic        Done;
  logic        Overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] mem [32];
  int          rd_q[$];
  int          wr_cnt = 0;
  int          clash  = 0;

  mem_accumulator #(.DATA_W(16), .ADDR_W(5)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr), .Count(Count),
    .DestAddr(DestAddr), .Mode(Mode), .DataOut(DataOut), .Address(Address),
    .ReadEnable(ReadEnable), .WriteEnable(WriteEnable), .DataIN(DataIN),
    .Ready(Ready), .Done(Done), .Overflow(Overflow)
  );

  always #5 Clock = ~Clock;

  // synchronous memory with one-cycle read latency, plus a strobe monitor
  always @(posedge Clock) begin
    if (!Reset) begin
      if (ReadEnable && WriteEnable) clash++;
      if (ReadEnable) begin
        rd_q.push_back(int'(Address));
        DataOut <= mem[Address];
      end
      if (WriteEnable) begin
        mem[Address] = DataIN;
        wr_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: fold the words arithmetically, straight from the mode definitions.
  task automatic model(input int base, input int cnt, input int mode,
                       output logic [15:0] res, output logic ovf);
    longint acc;
    longint d;
    acc = (mode == 3) ? 65535 : 0;
    ovf = 1'b0;
    for (int k = 0; k < cnt; k++) begin
      d = longint'(mem[(base + k) % 32]);
      case (mode)
        0: acc = (acc + d) % 65536;
        1: begin
          if (acc + d > 65535) begin acc = 65535; ovf = 1'b1; end
          else acc = acc + d;
        end
        2: if (d > acc) acc = d;
        default: if (d < acc) acc = d;
      endcase
    end
    res = acc[15:0];
  endtask

  task automatic run_job(input int base, input int cnt, input int dest, input int mode,
                         input int glitch, output int lat);
    int cyc;
    rd_q.delete();
    wr_cnt = 0;
    clash  = 0;
    @(negedge Clock);
    BaseAddr = 5'(base); Count = 6'(cnt); DestAddr = 5'(dest); Mode = 2'(mode);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    cyc = 1;
    while (cyc < 200 && !Done) begin
      if (cyc == glitch) begin
        Start = 1'b1; BaseAddr = ~5'(base); Count = 6'd1;
        DestAddr = 5'(dest + 1); Mode = ~2'(mode);
      end else begin
        Start = 1'b0;
      end
      @(negedge Clock);
      cyc++;
    end
    Start = 1'b0;
    lat = Done ? cyc : -1;
  endtask

  task automatic check_job(input string tag, input int base, input int cnt, input int dest,
                           input logic [15:0] exp_res, input logic exp_ovf, input int lat);
    bit ok;
    chk({tag, " latency"}, 32'(lat), 32'(2 * cnt + 2));
    chk({tag, " result"}, {16'h0, mem[dest]}, {16'h0, exp_res});
    chk({tag, " overflow"}, {31'h0, Overflow}, {31'h0, exp_ovf});
    ok = (rd_q.size() == cnt);
    for (int k = 0; k < rd_q.size() && ok; k++)
      if (rd_q[k] != (base + k) % 32) ok = 1'b0;
    chk({tag, " read_addrs"}, {31'h0, ok}, 32'h1);
    @(negedge Clock);
    chk({tag, " done_pulse_ready"}, {30'h0, Done, Ready}, 32'h1);
    chk({tag, " one_write_no_clash"}, 32'(wr_cnt * 16 + clash), 32'h10);
  endtask

  typedef struct {
    logic [4:0]  base;
    logic [5:0]  cnt;
    logic [4:0]  dest;
    logic [1:0]  mode;
    logic [15:0] exp_res;
    logic        exp_ovf;
    logic        setup_b;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          lat;
    int          b, c, d, m;
    logic [15:0] r;
    logic        o;

    vecs[0] = '{5'd0,  6'd4, 5'd10, 2'd0, 16'd10,   1'b0, 1'b0};
    vecs[1] = '{5'd4,  6'd3, 5'd12, 2'd2, 16'h9000, 1'b0, 1'b0};
    vecs[2] = '{5'd4,  6'd3, 5'd13, 2'd3, 16'd3,    1'b0, 1'b0};
    vecs[3] = '{5'd0,  6'd0, 5'd2,  2'd3, 16'hFFFF, 1'b0, 1'b0};
    vecs[4] = '{5'd30, 6'd3, 5'd20, 2'd1, 16'hFFFF, 1'b1, 1'b1};
    vecs[5] = '{5'd30, 6'd3, 5'd21, 2'd0, 16'h0006, 1'b0, 1'b0};

    for (int i = 0; i < 32; i++) mem[i] = 16'h0;
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4;
    mem[4] = 16'd7; mem[5] = 16'h9000; mem[6] = 16'd3;

    #1;
    chk("reset outputs", {Ready, Done, Overflow, ReadEnable, WriteEnable, Address, DataIN},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0});
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].setup_b) begin
        mem[30] = 16'hFFFF; mem[31] = 16'd2; mem[0] = 16'd5;
      end
      run_job(int'(vecs[i].base), int'(vecs[i].cnt), int'(vecs[i].dest), int'(vecs[i].mode), -1, lat);
      check_job($sformatf("vec%0d", i), int'(vecs[i].base), int'(vecs[i].cnt), int'(vecs[i].dest),
                vecs[i].exp_res, vecs[i].exp_ovf, lat);
    end

    // Reset while folding a 4-word job: immediate reset outputs, no write, then a clean job
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3; mem[3] = 16'd4; mem[15] = 16'hABCD;
    rd_q.delete(); wr_cnt = 0;
    @(negedge Clock);
    BaseAddr = 5'd0; Count = 6'd4; DestAddr = 5'd15; Mode = 2'd0; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    chk("mid-job read strobe", {31'h0, ReadEnable}, 32'h1);
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("async reset outputs", {Ready, Done, Overflow, ReadEnable, WriteEnable, Address, DataIN},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0});
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    repeat (12) @(negedge Clock);
    chk("abort no write", {wr_cnt[15:0], mem[15]}, {16'd0, 16'hABCD});
    run_job(0, 4, 15, 0, -1, lat);
    check_job("after reset", 0, 4, 15, 16'd10, 1'b0, lat);

    // Start pulsed during READ with different parameters must be ignored
    mem[8] = 16'd100; mem[9] = 16'd200; mem[10] = 16'd300;
    run_job(8, 3, 25, 0, 1, lat);
    check_job("start in READ", 8, 3, 25, 16'd600, 1'b0, lat);
    repeat (10) @(negedge Clock);
    chk("no second job", 32'(wr_cnt), 32'd1);

    for (int t = 0; t < 40; t++) begin
      if (t % 4 == 0)
        for (int i = 0; i < 32; i++)
          mem[i] = (t % 8 == 0) ? 16'($urandom_range(16'h8000, 16'hFFFF)) : 16'($urandom);
      b = $urandom_range(0, 31);
      c = $urandom_range(0, 32);
      d = $urandom_range(0, 31);
      m = $urandom_range(0, 3);
      model(b, c, m, r, o);
      run_job(b, c, d, m, (t % 5 == 0) ? 1 : -1, lat);
      check_job($sformatf("rand%0d", t), b, c, d, r, o, lat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
